// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, instruction field positions
// and the opcode/func codes used by control and ALU.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_e;

    // Instruction field bit positions
    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned SH_HI  = 10;
    localparam int unsigned SH_LO  = 6;
    localparam int unsigned FN_HI  = 5;
    localparam int unsigned FN_LO  = 0;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned JA_HI  = 25;

    // Opcodes and R-type function codes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, single-outstanding imem request FSM, IR latch,
// field split, redirect handling and sticky timeout error.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [5:0]  OPcode,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic [25:0] jaddr,
    output logic [31:0] pc_ir,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state, state_d;
    logic [31:0]      pc, pc_d;
    logic [31:0]      ir, ir_d;
    logic [31:0]      pc_ir_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_d;

    // Next-state, PC, IR and timeout counter computation
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        pc_ir_d = pc_ir;
        cnt_d   = cnt;
        err_d   = fetch_err;

        unique case (state)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_ir_d = pc;
                    pc_d    = pc + 32'd4;
                    cnt_d   = '0;
                    state_d = S_VALID;
                end else if (cnt == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_VALID: begin
                if (!stall) state_d = S_REQ;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides whatever the state case decided: a same-cycle
        // ack is discarded and a same-cycle timeout is cancelled.
        if (redirect_valid && state != S_ERR) begin
            pc_d    = word_align(redirect_pc);
            ir_d    = ir;
            pc_ir_d = pc_ir;
            cnt_d   = '0;
            err_d   = fetch_err;
            state_d = S_REQ;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            pc_ir     <= '0;
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            pc_ir     <= pc_ir_d;
            cnt       <= cnt_d;
            fetch_err <= err_d;
        end
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_VALID);
    assign pc_plus4    = pc_ir + 32'd4;

    assign OPcode = ir[OP_HI:OP_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign shamt  = ir[SH_HI:SH_LO];
    assign func   = ir[FN_HI:FN_LO];
    assign imm    = ir[IMM_HI:0];
    assign jaddr  = ir[JA_HI:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: vector table for the normal
// fetch/stall/redirect flow, hand sequences for timeout and PC wrap/reset.
module tb_instr_fetch;

    localparam logic [31:0] ADD_W = 32'h0000_0020;
    localparam logic [31:0] SUB_W = 32'h0000_0022;
    localparam logic [31:0] ADDI_W = 32'h2001_0005;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: default RESET_PC
    logic        rst_n, ack, stall, rv;
    logic [31:0] rdata, rpc;
    logic        req, valid, err;
    logic [31:0] addr, pc_ir, pc4;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] ja;

    // DUT 1: RESET_PC at top of address space
    logic        rst_n1, ack1, stall1, rv1;
    logic [31:0] rdata1, rpc1;
    logic        req1, valid1, err1;
    logic [31:0] addr1, pc_ir1, pc41;
    logic [5:0]  op1, fn1;
    logic [4:0]  rs1, rt1, rd1, sh1;
    logic [15:0] imm1;
    logic [25:0] ja1;

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16), .CNT_W(5)) u0 (
        .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr),
        .imem_ack(ack), .imem_rdata(rdata), .stall(stall),
        .redirect_valid(rv), .redirect_pc(rpc), .instr_valid(valid),
        .OPcode(op), .func(fn), .rs(rs), .rt(rt), .rd(rd), .shamt(sh),
        .imm(imm), .jaddr(ja), .pc_ir(pc_ir), .pc_plus4(pc4), .fetch_err(err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16), .CNT_W(5)) u1 (
        .clk(clk), .rst_n(rst_n1), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_rdata(rdata1), .stall(stall1),
        .redirect_valid(rv1), .redirect_pc(rpc1), .instr_valid(valid1),
        .OPcode(op1), .func(fn1), .rs(rs1), .rt(rt1), .rd(rd1), .shamt(sh1),
        .imm(imm1), .jaddr(ja1), .pc_ir(pc_ir1), .pc_plus4(pc41), .fetch_err(err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, ack, stall, rv;
        logic [31:0] rdata, rpc;
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_pc_ir, e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                                input logic s, input logic v, input logic [31:0] p,
                                input logic eq, input logic ev, input logic [31:0] ea,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t t;
        t.rst_n = r; t.ack = a; t.rdata = d; t.stall = s; t.rv = v; t.rpc = p;
        t.e_req = eq; t.e_valid = ev; t.e_addr = ea; t.e_pc_ir = ep; t.e_ir = ei;
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ei;
        rst_n = 0; ack = 0; rdata = '0; stall = 0; rv = 0; rpc = '0;
        rst_n1 = 0; ack1 = 0; rdata1 = '0; stall1 = 0; rv1 = 0; rpc1 = '0;

        //          rst ack rdata   stl rv rpc            req val addr          pc_ir         ir
        tbl.push_back(mk(0, 0, '0,    0, 0, '0,           0, 0, 32'h0000_0000, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, '0,    0, 0, '0,           0, 0, 32'h0000_0000, 32'h0,        32'h0));
        // basic fetch loop, ack on every request
        tbl.push_back(mk(1, 0, '0,    0, 0, '0,           1, 0, 32'h0000_0000, 32'h0,        32'h0));
        tbl.push_back(mk(1, 1, ADD_W, 0, 0, '0,           0, 1, 32'h0000_0004, 32'h0,        ADD_W));
        tbl.push_back(mk(1, 0, '0,    0, 0, '0,           1, 0, 32'h0000_0004, 32'h0,        ADD_W));
        tbl.push_back(mk(1, 1, ADD_W, 0, 0, '0,           0, 1, 32'h0000_0008, 32'h4,        ADD_W));
        tbl.push_back(mk(1, 0, '0,    0, 0, '0,           1, 0, 32'h0000_0008, 32'h4,        ADD_W));
        tbl.push_back(mk(1, 1, ADD_W, 0, 0, '0,           0, 1, 32'h0000_000C, 32'h8,        ADD_W));
        // stall held five cycles in VALID
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, '0, 1, 0, '0,          0, 1, 32'h0000_000C, 32'h8,        ADD_W));
        tbl.push_back(mk(1, 0, '0,    0, 0, '0,           1, 0, 32'h0000_000C, 32'h8,        ADD_W));
        tbl.push_back(mk(1, 1, ADD_W, 0, 0, '0,           0, 1, 32'h0000_0010, 32'hC,        ADD_W));
        // redirect beats stall, low address bits cleared
        tbl.push_back(mk(1, 0, '0,    1, 1, 32'h0000_0103, 1, 0, 32'h0000_0100, 32'hC,       ADD_W));
        tbl.push_back(mk(1, 1, SUB_W, 0, 0, '0,           0, 1, 32'h0000_0104, 32'h100,      SUB_W));
        tbl.push_back(mk(1, 0, '0,    0, 0, '0,           1, 0, 32'h0000_0104, 32'h100,      SUB_W));
        // redirect together with ack: data dropped, fetch re-issued
        tbl.push_back(mk(1, 1, ADDI_W, 0, 1, 32'h0000_0200, 1, 0, 32'h0000_0200, 32'h100,    SUB_W));
        tbl.push_back(mk(1, 1, ADDI_W, 0, 0, '0,          0, 1, 32'h0000_0204, 32'h200,      ADDI_W));
        // reset while VALID
        tbl.push_back(mk(0, 0, '0,    0, 0, '0,           0, 0, 32'h0000_0000, 32'h0,        32'h0));

        for (int n = 0; n < tbl.size(); n++) begin
            rst_n = tbl[n].rst_n; ack = tbl[n].ack; rdata = tbl[n].rdata;
            stall = tbl[n].stall; rv = tbl[n].rv; rpc = tbl[n].rpc;
            tick();
            ei = tbl[n].e_ir;
            chk($sformatf("v%0d imem_req", n),    {31'b0, req},   {31'b0, tbl[n].e_req});
            chk($sformatf("v%0d instr_valid", n), {31'b0, valid}, {31'b0, tbl[n].e_valid});
            chk($sformatf("v%0d imem_addr", n),   addr,  tbl[n].e_addr);
            chk($sformatf("v%0d pc_ir", n),       pc_ir, tbl[n].e_pc_ir);
            chk($sformatf("v%0d pc_plus4", n),    pc4,   tbl[n].e_pc_ir + 32'd4);
            chk($sformatf("v%0d fetch_err", n),   {31'b0, err}, 32'h0);
            chk($sformatf("v%0d OPcode", n), {26'b0, op},  {26'b0, ei[31:26]});
            chk($sformatf("v%0d func", n),   {26'b0, fn},  {26'b0, ei[5:0]});
            chk($sformatf("v%0d rs", n),     {27'b0, rs},  {27'b0, ei[25:21]});
            chk($sformatf("v%0d rt", n),     {27'b0, rt},  {27'b0, ei[20:16]});
            chk($sformatf("v%0d rd", n),     {27'b0, rd},  {27'b0, ei[15:11]});
            chk($sformatf("v%0d shamt", n),  {27'b0, sh},  {27'b0, ei[10:6]});
            chk($sformatf("v%0d imm", n),    {16'b0, imm}, {16'b0, ei[15:0]});
            chk($sformatf("v%0d jaddr", n),  {6'b0, ja},   {6'b0, ei[25:0]});
        end

        // Timeout: 16 REQ cycles without ack raise the sticky error
        rst_n = 1; ack = 0; stall = 0; rv = 0;
        tick();
        chk("to enter REQ", {31'b0, req}, 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("to wait%0d req", i), {31'b0, req}, 32'h1);
            chk($sformatf("to wait%0d err", i), {31'b0, err}, 32'h0);
        end
        tick();
        chk("to err set",   {31'b0, err},   32'h1);
        chk("to req drop",  {31'b0, req},   32'h0);
        chk("to valid low", {31'b0, valid}, 32'h0);
        // ERR ignores ack and redirect
        ack = 1; rdata = ADDI_W; rv = 1; rpc = 32'h0000_0400;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("err hold%0d err", i),  {31'b0, err}, 32'h1);
            chk($sformatf("err hold%0d req", i),  {31'b0, req}, 32'h0);
            chk($sformatf("err hold%0d addr", i), addr, 32'h0000_0000);
        end
        ack = 0; rv = 0; rst_n = 0;
        tick();
        chk("err cleared by reset", {31'b0, err}, 32'h0);

        // Wrap from top of address space, then reset mid-REQ
        tick();
        chk("wrap reset addr",  addr1, 32'hFFFF_FFFC);
        chk("wrap reset pc+4",  pc41,  32'h0000_0004);
        rst_n1 = 1;
        tick();
        chk("wrap req",         {31'b0, req1}, 32'h1);
        chk("wrap req addr",    addr1, 32'hFFFF_FFFC);
        ack1 = 1; rdata1 = ADD_W;
        tick();
        ack1 = 0;
        chk("wrap valid",       {31'b0, valid1}, 32'h1);
        chk("wrap pc_ir",       pc_ir1, 32'hFFFF_FFFC);
        chk("wrap pc_plus4",    pc41,   32'h0000_0000);
        chk("wrap next addr",   addr1,  32'h0000_0000);
        tick();
        chk("wrap refetch req", {31'b0, req1}, 32'h1);
        chk("wrap refetch addr", addr1, 32'h0000_0000);
        rst_n1 = 0; ack1 = 1; rdata1 = SUB_W;
        tick();
        ack1 = 0;
        chk("midreq rst req",   {31'b0, req1},   32'h0);
        chk("midreq rst valid", {31'b0, valid1}, 32'h0);
        chk("midreq rst addr",  addr1,  32'hFFFF_FFFC);
        chk("midreq rst pc_ir", pc_ir1, 32'h0000_0000);
        chk("midreq rst op",    {26'b0, op1}, 32'h0);
        chk("midreq rst err",   {31'b0, err1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
